adc083000_cfg_seq: RTL

Command sequencer that sits directly upstream of the ADC083000 serial-control block and generates its 32-bit `sdata_bus` control word. Software writes (register address, 16-bit data, chip mask) arrive over a valid/ready handshake and are buffered in a small FIFO. Each command is presented on `sdata_bus` with the trigger bit held long enough for the sclk-domain edge detector (sys_clk/16) to see it, then the block waits out the SPI frame. The next command is issued only after that wait, so software never has to poll or hand-pace writes.

---
 rtl/adc083000_cfg_pkg.sv | 38 +++
 rtl/adc083000_cfg_fifo.sv | 58 +++++
 rtl/adc083000_cfg_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/adc083000_cfg_pkg.sv
// Shared types and constants for the ADC083000 configuration sequencer.
//   state_e   : sequencer FSM states
//   cmd_t     : buffered software command {mask, addr, data}
//   cmd_word  : builds the 32-bit sdata_bus control word from a command
package adc083000_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int unsigned TRIG_BIT = 24;
  localparam int unsigned MASK_LSB = 25;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned CMD_W    = 22;
  localparam int unsigned WORD_W   = 32;

  // Trigger low, both chip masks high: chip-selects follow idle-high chip_sel.
  localparam logic [WORD_W-1:0] IDLE_WORD = 32'h0600_0000;

  typedef struct packed {
    logic [1:0]  mask;
    logic [3:0]  addr;
    logic [15:0] data;
  } cmd_t;

  function automatic logic [WORD_W-1:0] cmd_word(input cmd_t c, input logic trig);
    logic [WORD_W-1:0] w;
    w                   = '0;
    w[MASK_LSB +: 2]    = c.mask;
    w[TRIG_BIT]         = trig;
    w[ADDR_LSB +: 4]    = c.addr;
    w[15:0]             = c.data;
    return w;
  endfunction

endpackage

// File: rtl/adc083000_cfg_fifo.sv
// Synchronous first-word fall-through FIFO.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write strobe and data (ignored when full)
//   pop_i             : read strobe (ignored when empty)
//   rdata_o           : head entry, valid whenever !empty_o
//   full_o, empty_o   : status
//   level_o           : number of stored entries (registered)
module adc083000_cfg_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 22
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage needs no reset; only entries below level are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/adc083000_cfg_seq.sv
// Command sequencer driving the ADC083000 serial-control word.
//   sys_clk, reset             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake (ready = FIFO not full)
//   cmd_addr/cmd_data/cmd_mask : register address, data, chip mask
//   sdata_bus                  : control word {mask, trigger, addr, data}
//   busy                       : FSM active or commands pending
//   fifo_level                 : entries buffered
//   drop_cnt                   : saturating count of mask==0 commands dropped
module adc083000_cfg_seq
  import adc083000_cfg_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TRIG_CYCLES = 64,
  parameter int unsigned WAIT_CYCLES = 640
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_addr,
  input  logic [15:0]             cmd_data,
  input  logic [1:0]              cmd_mask,
  output logic [31:0]             sdata_bus,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [7:0]              drop_cnt
);

  localparam int unsigned CNT_MAX = (TRIG_CYCLES > WAIT_CYCLES) ? TRIG_CYCLES : WAIT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [7:0]         drop_q, drop_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [CMD_W-1:0]   fifo_rdata;
  cmd_t               wr_cmd;
  cmd_t               head;

  assign wr_cmd = '{mask: cmd_mask, addr: cmd_addr, data: cmd_data};
  assign head   = cmd_t'(fifo_rdata);

  adc083000_cfg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (reset),
    .push_i  (cmd_valid & cmd_ready),
    .wdata_i (wr_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= IDLE_WORD;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state: one shared down-counter times both the trigger and the frame wait.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    drop_d   = drop_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.mask != 2'b00) begin
            word_d  = cmd_word(head, 1'b1);
            cnt_d   = CNT_W'(TRIG_CYCLES - 1);
            state_d = TRIG;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      TRIG: begin
        if (cnt_q == '0) begin
          word_d[TRIG_BIT] = 1'b0;
          cnt_d            = CNT_W'(WAIT_CYCLES - 1);
          state_d          = WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          word_d  = IDLE_WORD;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdata_bus = word_q;
  assign drop_cnt  = drop_q;
  assign cmd_ready = ~fifo_full;
  assign busy      = (state_q != IDLE) | ~fifo_empty;

endmodule
